// File: rtl/frame_loader.sv
// frame_loader: turns a valid/ready byte stream with a start-of-frame marker
// into raster-order write strobes for the 160x120 8-bit frame memory.
// Tracks frame sync, pulses sync_err on dropped or resynchronising beats and
// frame_done when the last pixel of a frame is written.
//
// Ports:
//   clk, reset        core clock, asynchronous active-low reset
//   in_data/in_valid  pixel byte and its valid qualifier
//   in_sof            marks in_data as pixel (0,0)
//   in_ready          beat accepted this cycle when in_valid && in_ready (comb)
//   stall             memory write port unavailable, blocks acceptance
//   wr_en/wr_x/wr_y/wr_data  registered write strobe, one cycle after accept
//   busy              frame load in progress
//   frame_done        one-cycle pulse aligned with the last pixel's write
//   sync_err          one-cycle pulse on a dropped or resync beat
//   frame_count       completed frames, wraps 255 -> 0
module frame_loader #(
  parameter int unsigned IMG_WIDTH  = 160,
  parameter int unsigned IMG_HEIGHT = 120,
  parameter int unsigned XW         = $clog2(IMG_WIDTH),
  parameter int unsigned YW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  input  logic          stall,
  output logic          wr_en,
  output logic [XW-1:0] wr_x,
  output logic [YW-1:0] wr_y,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic          sync_err,
  output logic [7:0]    frame_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [1:0]    state, state_n;
  logic [XW-1:0] x, x_n, wr_x_n;
  logic [YW-1:0] y, y_n, wr_y_n;
  logic [7:0]    wr_data_n;
  logic          wr_en_n, sync_err_n, done_n;
  logic          accept;

  // in_ready is low during reset, during the one DONE cycle and under stall.
  assign in_ready = reset && !stall && (state != DONE);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == LOAD);

  // Next-state, address counters and write-path decode.
  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    wr_en_n    = 1'b0;
    wr_x_n     = wr_x;
    wr_y_n     = wr_y;
    wr_data_n  = wr_data;
    sync_err_n = 1'b0;
    done_n     = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            wr_en_n   = 1'b1;
            wr_x_n    = '0;
            wr_y_n    = '0;
            wr_data_n = in_data;
            x_n       = XW'(1);
            y_n       = '0;
            state_n   = LOAD;
          end else begin
            // Beat outside a frame: dropped.
            sync_err_n = 1'b1;
          end
        end
      end

      LOAD: begin
        if (accept) begin
          wr_en_n   = 1'b1;
          wr_data_n = in_data;
          if (in_sof) begin
            // Resync restarts the frame, including on the final pixel.
            wr_x_n     = '0;
            wr_y_n     = '0;
            x_n        = XW'(1);
            y_n        = '0;
            sync_err_n = 1'b1;
          end else begin
            wr_x_n = x;
            wr_y_n = y;
            if (x == X_LAST) begin
              x_n = '0;
              if (y == Y_LAST) begin
                y_n     = '0;
                state_n = DONE;
                done_n  = 1'b1;
              end else begin
                y_n = y + YW'(1);
              end
            end else begin
              x_n = x + XW'(1);
            end
          end
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Address counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x           <= '0;
      y           <= '0;
      wr_en       <= 1'b0;
      wr_x        <= '0;
      wr_y        <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      frame_count <= '0;
    end else begin
      x          <= x_n;
      y          <= y_n;
      wr_en      <= wr_en_n;
      wr_x       <= wr_x_n;
      wr_y       <= wr_y_n;
      wr_data    <= wr_data_n;
      frame_done <= done_n;
      sync_err   <= sync_err_n;
      if (done_n) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule
